// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and defaults for the button event path
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int DEF_LONG_CYCLES = 8;
  localparam int DEF_GAP_CYCLES  = 4;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - one-sample history of a synchronous level, yielding rise and fall strobes
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic rise,
  output logic fall
);

  logic s_q;
  logic s_d;

  assign s_d = s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= RESET_VAL;
    end else begin
      s_q <= s_d;
    end
  end

  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

endmodule

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - turns a debounced button level into press/short/long/double pulses and a press count
module press_classifier
  import button_pkg::*;
#(
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  output logic             press,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic [CNT_W-1:0] press_count
);

  if (LONG_CYCLES < 2 || GAP_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("press_classifier: need LONG_CYCLES >= 2, GAP_CYCLES >= 1, CNT_W >= 1");
  end

  localparam int HC_W = $clog2(LONG_CYCLES + 1);
  localparam int GC_W = $clog2(GAP_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(LONG_CYCLES);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(LONG_CYCLES - 1);
  localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_CYCLES - 1);

  logic rise;
  logic fall;

  // Reset history high so a button held through reset is not reported as a press.
  edge_detect #(
    .RESET_VAL(1'b1)
  ) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  state_e           state_q, state_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [GC_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic             second_q, second_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    second_d   = second_q;
    press_d    = rise;
    short_d    = 1'b0;
    long_d     = 1'b0;
    double_d   = 1'b0;
    count_d    = count_q + CNT_W'(rise);

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_HELD;
          hold_cnt_d = HC_W'(1);
          second_d   = 1'b0;
        end
      end
      // HELD is only entered on a rise, so a low sample here is always a fall.
      ST_HELD: begin
        if (fall) begin
          short_d = 1'b1;
          if (second_q) begin
            double_d = 1'b1;
            second_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end else begin
          if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
          if (hold_cnt_q == HOLD_LAST) begin
            long_d   = 1'b1;
            second_d = 1'b0;
            state_d  = ST_LONG;
          end
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (rise) begin
          state_d    = ST_HELD;
          hold_cnt_d = HC_W'(1);
          second_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GC_W'(1);
          if (gap_cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      second_q   <= 1'b0;
      press_q    <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      double_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      second_q   <= second_d;
      press_q    <= press_d;
      short_q    <= short_d;
      long_q     <= long_d;
      double_q   <= double_d;
      count_q    <= count_d;
    end
  end

  assign press        = press_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign press_count  = count_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - self-checking bench for press_classifier
module tb_press_classifier;

  localparam int LONG = 8;
  localparam int GAP  = 4;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic       press;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic [7:0] press_count;

  press_classifier #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s),
    .press       (press),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #30 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: reasons about presses as runs of high samples and
  // the distance in samples between a short release and the next rise.
  bit         m_prev;
  bit         m_active;
  bit         m_long_done;
  bit         m_is_second;
  bit         m_armed;
  int         m_run;
  longint     m_cyc;
  longint     m_rel;
  bit         exp_press, exp_short, exp_long, exp_double;
  logic [7:0] exp_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev      = 1'b1;
      m_active    = 1'b0;
      m_long_done = 1'b0;
      m_is_second = 1'b0;
      m_armed     = 1'b0;
      m_run       = 0;
      m_cyc       = 0;
      m_rel       = 0;
      exp_press   = 1'b0;
      exp_short   = 1'b0;
      exp_long    = 1'b0;
      exp_double  = 1'b0;
      exp_count   = 8'd0;
    end else begin
      m_cyc      = m_cyc + 1;
      exp_press  = 1'b0;
      exp_short  = 1'b0;
      exp_long   = 1'b0;
      exp_double = 1'b0;
      if (s && !m_prev) begin
        exp_press = 1'b1;
        exp_count = exp_count + 8'd1;
        m_active    = 1'b1;
        m_run       = 1;
        m_long_done = 1'b0;
        m_is_second = m_armed && (m_cyc - m_rel <= GAP);
        m_armed     = 1'b0;
      end else if (s && m_active && !m_long_done) begin
        m_run = m_run + 1;
      end
      if (s && m_active && !m_long_done && m_run == LONG) begin
        exp_long    = 1'b1;
        m_long_done = 1'b1;
      end
      if (!s && m_prev && m_active) begin
        if (!m_long_done) begin
          exp_short = 1'b1;
          if (m_is_second) begin
            exp_double = 1'b1;
          end else begin
            m_armed = 1'b1;
            m_rel   = m_cyc;
          end
        end
        m_active = 1'b0;
      end
      m_prev = s;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_press", int'(press), int'(exp_press));
      check("model_short", int'(short_press), int'(exp_short));
      check("model_long", int'(long_press), int'(exp_long));
      check("model_double", int'(double_press), int'(exp_double));
      check("model_count", int'(press_count), int'(exp_count));
    end
  end

  // Directed-phase observation, owned by the stimulus process only.
  int idx, n_press, n_short, n_long, n_double, n_dbl_short;
  int press_at, short_at, long_at;

  task automatic obs_clear();
    idx = 0; n_press = 0; n_short = 0; n_long = 0; n_double = 0; n_dbl_short = 0;
    press_at = -1; short_at = -1; long_at = -1;
  endtask

  // Called at a falling edge: apply v, then return at the next falling edge
  // once the rising edge has sampled v and the outputs reflect it.
  task automatic drive(input logic v);
    s = v;
    @(negedge clk);
    idx = idx + 1;
    if (press) begin n_press = n_press + 1; press_at = idx; end
    if (short_press) begin n_short = n_short + 1; short_at = idx; end
    if (long_press) begin n_long = n_long + 1; long_at = idx; end
    if (double_press) n_double = n_double + 1;
    if (double_press && short_press) n_dbl_short = n_dbl_short + 1;
  endtask

  task automatic drive_n(input logic v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic do_reset(input logic s_val);
    #5;
    rst_n = 1'b0;
    s = s_val;
    @(negedge clk);
    #5;
    rst_n = 1'b1;
    @(negedge clk);
    obs_clear();
  endtask

  initial begin
    rst_n = 1'b0;
    s = 1'b0;
    obs_clear();
    repeat (2) @(negedge clk);
    check("rst_press", int'(press), 0);
    check("rst_short", int'(short_press), 0);
    check("rst_long", int'(long_press), 0);
    check("rst_double", int'(double_press), 0);
    check("rst_count", int'(press_count), 0);
    chk_on = 1'b1;
    #5;
    rst_n = 1'b1;
    @(negedge clk);

    // short press: high 3 then low
    obs_clear();
    drive_n(1'b1, 3);
    drive_n(1'b0, 6);
    check("t1_npress", n_press, 1);
    check("t1_press_at", press_at, 1);
    check("t1_nshort", n_short, 1);
    check("t1_short_at", short_at, 4);
    check("t1_nlong", n_long, 0);
    check("t1_ndouble", n_double, 0);
    check("t1_count", int'(press_count), 1);

    // long press: high 10
    do_reset(1'b0);
    drive_n(1'b1, 10);
    drive_n(1'b0, 6);
    check("t2_nlong", n_long, 1);
    check("t2_long_at", long_at, 8);
    check("t2_nshort", n_short, 0);
    check("t2_count", int'(press_count), 1);

    // double press: high 2, low 2, high 2, low
    do_reset(1'b0);
    drive_n(1'b1, 2); drive_n(1'b0, 2); drive_n(1'b1, 2); drive_n(1'b0, 6);
    check("t3_npress", n_press, 2);
    check("t3_nshort", n_short, 2);
    check("t3_ndouble", n_double, 1);
    check("t3_dbl_with_short", n_dbl_short, 1);
    check("t3_dbl_at", short_at, 7);
    check("t3_count", int'(press_count), 2);

    // rise on the GAP-th edge after the release sample still counts
    do_reset(1'b0);
    drive_n(1'b1, 2); drive_n(1'b0, 4); drive_n(1'b1, 2); drive_n(1'b0, 6);
    check("t4_nshort", n_short, 2);
    check("t4_ndouble", n_double, 1);

    // one more low sample closes the window
    do_reset(1'b0);
    drive_n(1'b1, 2); drive_n(1'b0, 5); drive_n(1'b1, 2); drive_n(1'b0, 6);
    check("t5_nshort", n_short, 2);
    check("t5_ndouble", n_double, 0);

    // long second press yields long only
    do_reset(1'b0);
    drive_n(1'b1, 2); drive_n(1'b0, 2); drive_n(1'b1, 9); drive_n(1'b0, 6);
    check("t6_nshort", n_short, 1);
    check("t6_nlong", n_long, 1);
    check("t6_ndouble", n_double, 0);

    // button held through reset
    do_reset(1'b1);
    drive_n(1'b1, 10);
    check("t7_npress", n_press, 0);
    check("t7_nlong", n_long, 0);
    check("t7_count", int'(press_count), 0);
    drive(1'b0);
    drive(1'b1);
    check("t7_press_after", int'(press), 1);
    check("t7_count_after", int'(press_count), 1);
    drive_n(1'b0, 6);

    // wrap of the press counter, toggling every edge
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1);
      if (i == 254) check("t8_count_255", int'(press_count), 255);
      drive(1'b0);
    end
    check("t8_npress", n_press, 256);
    check("t8_count_wrap", int'(press_count), 0);
    drive_n(1'b0, 6);

    // asynchronous reset mid-hold
    do_reset(1'b0);
    drive(1'b0);
    drive(1'b1);
    check("t9_press_pulse", int'(press), 1);
    drive_n(1'b1, 4);
    check("t9_count_pre", int'(press_count), 1);
    #10;
    rst_n = 1'b0;
    #1;
    check("t9_press", int'(press), 0);
    check("t9_short", int'(short_press), 0);
    check("t9_long", int'(long_press), 0);
    check("t9_double", int'(double_press), 0);
    check("t9_count", int'(press_count), 0);
    @(negedge clk);
    #5;
    rst_n = 1'b1;
    @(negedge clk);
    obs_clear();
    drive_n(1'b1, 10);
    check("t9_nlong_after", n_long, 0);
    check("t9_npress_after", n_press, 0);
    check("t9_count_after", int'(press_count), 0);
    drive_n(1'b0, 4);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
